// File: rtl/ioctl_rom_dip_loader_if.sv
// hps_io ioctl download stream plus the ROM write req/ack handshake toward the core.
// master = hps_io/ROM target side, slave = the loader.
interface ioctl_rom_dip_loader_if #(
  parameter int REGION_AW = 16,
  parameter int RSEL_W    = 2
);
  logic                 ioctl_download;
  logic [7:0]           ioctl_index;
  logic                 ioctl_wr;
  logic [24:0]          ioctl_addr;
  logic [7:0]           ioctl_dout;
  logic                 ioctl_wait;
  logic                 rom_wr_req;
  logic [RSEL_W-1:0]    rom_region;
  logic [REGION_AW-1:0] rom_addr;
  logic [7:0]           rom_data;
  logic                 rom_wr_ack;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_wr_ack,
    input  ioctl_wait, rom_wr_req, rom_region, rom_addr, rom_data
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_wr_ack,
    output ioctl_wait, rom_wr_req, rom_region, rom_addr, rom_data
  );
endinterface

// File: rtl/ioctl_rom_dip_loader.sv
// Routes the hps_io ioctl stream: ROM bytes to NUM_REGIONS regions over req/ack,
// DIP bank and mod byte capture, plus download status and sticky error flags.
module ioctl_rom_dip_loader #(
  parameter int NUM_REGIONS = 4,
  parameter int REGION_AW   = 16,
  parameter int DIP_BYTES   = 8,
  parameter int ROM_INDEX   = 0,
  parameter int MOD_INDEX   = 1,
  parameter int DIP_INDEX   = 254
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  ioctl_rom_dip_loader_if.slave  bus,
  output logic [8*DIP_BYTES-1:0] dip_out,
  output logic [7:0]             mod_out,
  output logic                   mod_valid,
  output logic [24:0]            byte_count,
  output logic                   rom_loaded,
  output logic                   rom_done,
  output logic                   err_ovf,
  output logic                   err_proto
);
  localparam int RSEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [25:0] ROM_SIZE = 26'(NUM_REGIONS) << REGION_AW;
  localparam logic [7:0]  ROM_IDX  = 8'(ROM_INDEX);
  localparam logic [7:0]  MOD_IDX  = 8'(MOD_INDEX);
  localparam logic [7:0]  DIP_IDX  = 8'(DIP_INDEX);

  typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;
  state_t state, state_nxt;

  logic dl_p1, rom_active, end_pending, start_pending;
  logic is_rom, dl_rise, dl_fall, rom_wr, in_range;
  logic accept, ovf_evt, proto_evt, start_now, ack_seen;

  always_comb begin
    is_rom    = (bus.ioctl_index == ROM_IDX);
    dl_rise   = bus.ioctl_download & ~dl_p1;
    dl_fall   = ~bus.ioctl_download & dl_p1 & rom_active;
    rom_wr    = bus.ioctl_wr & is_rom;
    in_range  = ({1'b0, bus.ioctl_addr} < ROM_SIZE);
    accept    = (state == IDLE) && rom_wr && bus.ioctl_download && in_range;
    ovf_evt   = (state == IDLE) && rom_wr && bus.ioctl_download && !in_range;
    proto_evt = (state == WRITE) && rom_wr;
    ack_seen  = (state == WRITE) && bus.rom_wr_ack;
    // a start seen during the done pulse is deferred so the pulse and rom_loaded stick
    start_now = (state != FINISH) && ((dl_rise && is_rom) || start_pending);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)       state_nxt = WRITE;
               else if (dl_fall) state_nxt = FINISH;
      WRITE:   if (bus.rom_wr_ack) state_nxt = (end_pending || dl_fall) ? FINISH : IDLE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rom_done = (state == FINISH);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_p1          <= 1'b0;
      rom_active     <= 1'b0;
      end_pending    <= 1'b0;
      start_pending  <= 1'b0;
      bus.rom_wr_req <= 1'b0;
      bus.ioctl_wait <= 1'b0;
      rom_loaded     <= 1'b0;
      err_ovf        <= 1'b0;
      err_proto      <= 1'b0;
      byte_count     <= '0;
    end else begin
      dl_p1 <= bus.ioctl_download;
      if (dl_rise && is_rom) rom_active <= 1'b1;
      else if (dl_fall)      rom_active <= 1'b0;
      end_pending   <= (state == WRITE) && (state_nxt == WRITE) && (end_pending || dl_fall);
      start_pending <= (state == FINISH) && dl_rise && is_rom;

      if (accept) begin
        bus.rom_wr_req <= 1'b1;
        bus.ioctl_wait <= 1'b1;
      end else if (ack_seen) begin
        bus.rom_wr_req <= 1'b0;
        bus.ioctl_wait <= 1'b0;
      end

      if (start_now)              byte_count <= accept ? 25'd1 : 25'd0;
      else if (accept && byte_count != '1) byte_count <= byte_count + 25'd1;

      if (start_now)               rom_loaded <= 1'b0;
      else if (state == FINISH)    rom_loaded <= 1'b1;
      err_ovf   <= (err_ovf   & ~start_now) | ovf_evt;
      err_proto <= (err_proto & ~start_now) | proto_evt;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bus.rom_region <= '0;
      bus.rom_addr   <= '0;
      bus.rom_data   <= '0;
      dip_out        <= '0;
      mod_out        <= '0;
      mod_valid      <= 1'b0;
    end else begin
      if (accept) begin
        bus.rom_region <= bus.ioctl_addr[REGION_AW +: RSEL_W];
        bus.rom_addr   <= bus.ioctl_addr[REGION_AW-1:0];
        bus.rom_data   <= bus.ioctl_dout;
      end
      for (int n = 0; n < DIP_BYTES; n++) begin
        if (bus.ioctl_wr && bus.ioctl_index == DIP_IDX && bus.ioctl_addr == 25'(n))
          dip_out[8*n +: 8] <= bus.ioctl_dout;
      end
      if (bus.ioctl_wr && bus.ioctl_index == MOD_IDX && bus.ioctl_addr == 25'd0) begin
        mod_out   <= bus.ioctl_dout;
        mod_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ioctl_rom_dip_loader.sv
// Randomized bench for ioctl_rom_dip_loader: acts as hps_io and ROM target, checks
// against a transaction-level model of the ROM image, DIP bank, mod byte and status.
module tb_ioctl_rom_dip_loader;
  localparam int NUM_REGIONS = 4;
  localparam int REGION_AW   = 16;
  localparam int DIP_BYTES   = 8;
  localparam int RSEL_W      = 2;
  localparam int ROM_SPAN    = NUM_REGIONS << REGION_AW;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  ioctl_rom_dip_loader_if #(.REGION_AW(REGION_AW), .RSEL_W(RSEL_W)) bus ();

  logic [8*DIP_BYTES-1:0] dip_out;
  logic [7:0]  mod_out;
  logic        mod_valid, rom_loaded, rom_done, err_ovf, err_proto;
  logic [24:0] byte_count;

  ioctl_rom_dip_loader #(
    .NUM_REGIONS(NUM_REGIONS), .REGION_AW(REGION_AW), .DIP_BYTES(DIP_BYTES),
    .ROM_INDEX(0), .MOD_INDEX(1), .DIP_INDEX(254)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .bus(bus),
    .dip_out(dip_out), .mod_out(mod_out), .mod_valid(mod_valid),
    .byte_count(byte_count), .rom_loaded(rom_loaded), .rom_done(rom_done),
    .err_ovf(err_ovf), .err_proto(err_proto)
  );

  int n_vec = 0;
  int n_mis = 0;
  int done_cnt = 0;

  logic [7:0] m_dip [DIP_BYTES];
  logic [7:0] m_mod;
  logic       m_mod_valid, m_loaded, m_ovf, m_proto;
  int         m_count;
  logic [7:0] m_mem [int];
  logic [7:0] t_mem [int];

  always @(negedge clk_sys) if (rom_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DIP_BYTES; i++) m_dip[i] = 8'h00;
    m_mod = 8'h00; m_mod_valid = 1'b0; m_loaded = 1'b0;
    m_ovf = 1'b0;  m_proto = 1'b0;     m_count = 0;
  endtask

  task automatic check_status();
    logic [63:0] e = '0;
    for (int i = 0; i < DIP_BYTES; i++) e[8*i +: 8] = m_dip[i];
    chk("byte_count", byte_count, m_count);
    chk("rom_loaded", rom_loaded, m_loaded);
    chk("err_ovf",    err_ovf,    m_ovf);
    chk("err_proto",  err_proto,  m_proto);
    chk("dip_out",    dip_out,    e);
    chk("mod_out",    mod_out,    m_mod);
    chk("mod_valid",  mod_valid,  m_mod_valid);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    bus.ioctl_index = idx;
    bus.ioctl_download = 1'b1;
    tick();
    if (idx == 8'd0) begin
      m_count = 0; m_loaded = 1'b0; m_ovf = 1'b0; m_proto = 1'b0;
    end
    check_status();
  endtask

  task automatic end_dl(input bit is_rom);
    int d0 = done_cnt;
    bus.ioctl_download = 1'b0;
    tick();
    if (is_rom) begin
      chk("done_hi", rom_done, 1'b1);
      tick();
      chk("done_lo", rom_done, 1'b0);
      chk("done_once", done_cnt - d0, 1);
      m_loaded = 1'b1;
    end else begin
      tick();
      chk("no_done", done_cnt - d0, 0);
    end
    check_status();
  endtask

  // One ROM byte from hps_io, serviced by the target after 'delay' cycles of request.
  task automatic rom_byte(input logic [24:0] a, input logic [7:0] d, input int delay,
                          input bit proto, input bit drop, output bit ended);
    int d0;
    ended = 1'b0;
    bus.ioctl_addr = a; bus.ioctl_dout = d; bus.ioctl_wr = 1'b1;
    tick();
    bus.ioctl_wr = 1'b0;
    if (int'(a) < ROM_SPAN) begin
      m_count++;
      m_mem[int'(a)] = d;
      chk("req_set",  bus.rom_wr_req, 1'b1);
      chk("wait_set", bus.ioctl_wait, 1'b1);
      chk("region",   bus.rom_region, a >> REGION_AW);
      chk("raddr",    bus.rom_addr,   a % (1 << REGION_AW));
      chk("rdata",    bus.rom_data,   d);
      if (drop) bus.ioctl_download = 1'b0;
      for (int i = 0; i < delay; i++) begin
        if (proto && i == 0) begin
          bus.ioctl_addr = a ^ 25'd1; bus.ioctl_dout = ~d; bus.ioctl_wr = 1'b1;
          m_proto = 1'b1;
        end
        tick();
        bus.ioctl_wr = 1'b0;
        chk("req_hold",   bus.rom_wr_req, 1'b1);
        chk("wait_hold",  bus.ioctl_wait, 1'b1);
        chk("rdata_hold", bus.rom_data,   d);
      end
      t_mem[int'({bus.rom_region, bus.rom_addr})] = bus.rom_data;
      d0 = done_cnt;
      bus.rom_wr_ack = 1'b1;
      tick();
      bus.rom_wr_ack = 1'b0;
      chk("req_clr",  bus.rom_wr_req, 1'b0);
      chk("wait_clr", bus.ioctl_wait, 1'b0);
      if (drop) begin
        chk("done_after_ack", rom_done, 1'b1);
        tick();
        chk("done_end", rom_done, 1'b0);
        chk("done_once_drop", done_cnt - d0, 1);
        m_loaded = 1'b1;
        ended = 1'b1;
      end
    end else begin
      m_ovf = 1'b1;
      chk("ovf_noreq",  bus.rom_wr_req, 1'b0);
      chk("ovf_nowait", bus.ioctl_wait, 1'b0);
    end
    check_status();
  endtask

  task automatic side_byte(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_addr = a; bus.ioctl_dout = d; bus.ioctl_wr = 1'b1;
    tick();
    bus.ioctl_wr = 1'b0;
    if (bus.ioctl_index == 8'd254 && int'(a) < DIP_BYTES) m_dip[int'(a)] = d;
    else if (bus.ioctl_index == 8'd1 && a == 25'd0) begin
      m_mod = d; m_mod_valid = 1'b1;
    end
    chk("side_noreq", bus.rom_wr_req, 1'b0);
    check_status();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ended;
    reset = 1'b1;
    bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0; bus.ioctl_dout = '0; bus.rom_wr_ack = 1'b0;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_req",    bus.rom_wr_req, 1'b0);
    chk("rst_wait",   bus.ioctl_wait, 1'b0);
    chk("rst_region", bus.rom_region, 0);
    chk("rst_addr",   bus.rom_addr,   0);
    chk("rst_data",   bus.rom_data,   0);
    chk("rst_done",   rom_done,       1'b0);
    check_status();

    // directed ROM download across all four regions
    start_dl(8'd0);
    rom_byte(25'h00000, 8'h11, 3, 0, 0, ended);
    rom_byte(25'h10001, 8'h22, 3, 0, 0, ended);
    rom_byte(25'h20002, 8'h33, 3, 0, 0, ended);
    rom_byte(25'h3FFFF, 8'h44, 3, 0, 0, ended);
    chk("count4", byte_count, 4);
    rom_byte(25'h40000, 8'h55, 0, 0, 0, ended);
    chk("ovf_set", err_ovf, 1'b1);
    end_dl(1);

    // second download clears status; protocol error, then early download drop
    start_dl(8'd0);
    chk("ovf_cleared", err_ovf, 1'b0);
    rom_byte(25'h00123, 8'h5A, 2, 1, 0, ended);
    chk("proto_set", err_proto, 1'b1);
    rom_byte(25'h12345, 8'h77, 10, 0, 1, ended);

    start_dl(8'd254);
    side_byte(25'd1, 8'hA5);
    side_byte(25'd9, 8'h3C);
    end_dl(0);
    chk("dip_byte1", dip_out[15:8], 8'hA5);
    start_dl(8'd1);
    side_byte(25'd0, 8'h01);
    side_byte(25'd3, 8'hEE);
    end_dl(0);
    chk("mod_byte", mod_out, 8'h01);

    bus.rom_wr_ack = 1'b1;
    tick();
    bus.rom_wr_ack = 1'b0;
    chk("idle_ack_req", bus.rom_wr_req, 1'b0);
    check_status();

    for (int it = 0; it < 30; it++) begin
      int kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        int nb = $urandom_range(1, 6);
        start_dl(8'd0);
        ended = 1'b0;
        for (int b = 0; b < nb; b++) begin
          logic [24:0] a;
          int dly = $urandom_range(0, 5);
          bit pr = (dly > 0) && ($urandom_range(0, 5) == 0);
          bit dr = (b == nb - 1) && ($urandom_range(0, 3) == 0);
          if ($urandom_range(0, 7) == 0) a = 25'($urandom_range(ROM_SPAN, 25'h1FFFFFF));
          else a = 25'($urandom_range(0, ROM_SPAN - 1));
          rom_byte(a, 8'($urandom), dly, pr, dr, ended);
        end
        if (!ended) end_dl(1);
      end else begin
        logic [7:0] idx;
        case ($urandom_range(0, 2))
          0:       idx = 8'd254;
          1:       idx = 8'd1;
          default: idx = 8'($urandom_range(2, 253));
        endcase
        start_dl(idx);
        for (int b = 0; b < 3; b++) side_byte(25'($urandom_range(0, 11)), 8'($urandom));
        end_dl(0);
      end
    end

    foreach (m_mem[k]) chk("rom_image", t_mem.exists(k) ? t_mem[k] : 8'hxx, m_mem[k]);
    chk("rom_image_size", t_mem.num(), m_mem.num());

    // asynchronous reset in the middle of a pending write
    start_dl(8'd0);
    bus.ioctl_addr = 25'h00010; bus.ioctl_dout = 8'h99; bus.ioctl_wr = 1'b1;
    tick();
    bus.ioctl_wr = 1'b0;
    chk("pre_rst_req", bus.rom_wr_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_req",   bus.rom_wr_req, 1'b0);
    chk("arst_wait",  bus.ioctl_wait, 1'b0);
    chk("arst_dip",   dip_out,        0);
    chk("arst_modv",  mod_valid,      1'b0);
    bus.ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    chk("post_rst_req", bus.rom_wr_req, 1'b0);
    check_status();
    start_dl(8'd0);
    rom_byte(25'h00020, 8'h6B, 1, 0, 0, ended);
    end_dl(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/ioctl_rom_dip_loader.md
Name: ioctl_rom_dip_loader

Overview:
- Parametrised download router between hps_io's ioctl stream and the arcade core. It generalises the top level's inline DIP capture, mod latch and single-target ROM write.
- ROM bytes are demultiplexed into NUM_REGIONS equal-size regions over a req/ack handshake, with ioctl_wait back-pressure.
- Also provides a DIP bank of DIP_BYTES bytes, a mod byte with valid flag, a byte counter, load-complete status and sticky error flags.
- Sits in emu between hps_io and the game core.

Parameters:
- NUM_REGIONS, 4, number of ROM regions; each region is 2**REGION_AW bytes, packed contiguously from address 0.
- REGION_AW, 16, byte-address width of one region.
- DIP_BYTES, 8, DIP bytes captured; must be 1..32.
- ROM_INDEX, 0, ioctl_index value for ROM download.
- MOD_INDEX, 1, ioctl_index value for the mod byte.
- DIP_INDEX, 254, ioctl_index value for DIP settings.
- Localparam RSEL_W = max(1, clog2(NUM_REGIONS)).

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- ioctl_download, in, 1: download active.
- ioctl_index, in, 8: download target index.
- ioctl_wr, in, 1: one-cycle byte strobe.
- ioctl_addr, in, 25: byte address.
- ioctl_dout, in, 8: byte data.
- ioctl_wait, out, 1: stall request to hps_io.
- rom_wr_req, out, 1: ROM write pending.
- rom_region, out, RSEL_W: target region.
- rom_addr, out, REGION_AW: byte address within region.
- rom_data, out, 8: byte to write.
- rom_wr_ack, in, 1: target accepted the write.
- dip_out, out, 8*DIP_BYTES: DIP bank; byte n is at bits [8n+7:8n].
- mod_out, out, 8: mod byte.
- mod_valid, out, 1: mod byte has been written since reset.
- byte_count, out, 25: ROM bytes accepted in the current/last download.
- rom_loaded, out, 1: last ROM download completed.
- rom_done, out, 1: one-cycle completion pulse.
- err_ovf, out, 1: sticky; ROM address beyond the region map.
- err_proto, out, 1: sticky; ioctl_wr arrived while a write was pending.

Behaviour:
- Reset (async): all outputs 0, including dip_out, mod_out and byte_count. FSM goes to IDLE. Any pending request is dropped without an ack.
- FSM states: IDLE, WRITE, FINISH.
  - IDLE -> WRITE when ioctl_wr, ioctl_index==ROM_INDEX, ioctl_download=1 and addr < NUM_REGIONS<<REGION_AW.
    - On that edge: rom_region = addr[REGION_AW +: RSEL_W], rom_addr = addr[REGION_AW-1:0], rom_data = dout.
    - On that edge: rom_wr_req <= 1, ioctl_wait <= 1, byte_count += 1.
  - WRITE holds rom_wr_req, rom_region, rom_addr and rom_data stable until rom_wr_ack is sampled high.
    - Next edge after the ack: rom_wr_req <= 0 and ioctl_wait <= 0.
    - Returns to IDLE, or to FINISH if ioctl_download is already 0.
    - Minimum write latency is 2 cycles when the ack is asserted combinationally.
  - rom_wr_ack while in IDLE or FINISH is ignored.
  - Out-of-range ROM write in IDLE: byte dropped, err_ovf <= 1, byte_count unchanged, no wait.
  - ioctl_wr for ROM_INDEX while in WRITE: byte dropped, err_proto <= 1, pending request unaffected.
- Download start: rising edge of ioctl_download with index ROM_INDEX clears rom_loaded, byte_count, err_ovf and err_proto.
- Download end: falling edge of ioctl_download while a ROM download is in progress.
  - In IDLE: go to FINISH.
  - In WRITE: the falling edge is remembered; FINISH follows the ack.
  - FINISH: rom_done = 1 for exactly one cycle, rom_loaded <= 1, then IDLE.
- A new download starting in FINISH is handled after the pulse; the pulse is never lost.
- DIP capture: ioctl_wr with index DIP_INDEX and addr < DIP_BYTES writes dout into byte addr. Other addresses are ignored. No handshake; accepted in any FSM state.
- Mod capture: ioctl_wr with index MOD_INDEX and addr==0 sets mod_out <= dout and mod_valid <= 1. Nonzero addresses are ignored.
- Writes with any other index are ignored entirely.
- byte_count saturates at all-ones and does not wrap.

Test Plan:
- Reset, then a ROM download of 4 bytes at addr 0x00000, 0x10001, 0x20002, 0x3FFFF with ack asserted 3 cycles after each req (defaults) -> regions 0, 1, 2, 3; rom_addr 0x0000, 0x0001, 0x0002, 0xFFFF; ioctl_wait high until 1 cycle after each ack; byte_count=4; one rom_done pulse; rom_loaded=1.
- Write to addr 0x40000 -> err_ovf=1, no rom_wr_req, byte_count unchanged. Then a second ROM download -> err_ovf and rom_loaded clear at its start.
- Drop ioctl_download while in WRITE and delay the ack 10 cycles -> rom_done pulses exactly once, on the cycle after the FINISH transition that follows the ack.
- Second ioctl_wr during WRITE -> err_proto=1; the original rom_data is still presented and committed.
- DIP download of bytes 0xA5 at addr 1 and 0x3C at addr 9 (DIP_BYTES=8) -> dip_out[15:8]=0xA5, addr 9 ignored. Mod byte 0x01 at addr 0 -> mod_out=1, mod_valid=1.
- Assert reset asynchronously mid-WRITE -> rom_wr_req, ioctl_wait, dip_out and mod_valid are 0 immediately, before the next clock edge; the FSM is in IDLE after release.
